// File: rtl/fifo_stream_reader_if.sv
// Bundles the FIFO read port and the downstream valid/ready stream of fifo_stream_reader.
// master is the reader side; slave is the FIFO plus downstream consumer side.
interface fifo_stream_reader_if #(
   parameter int unsigned WIDTH = 8
);
   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_dout;
   logic             fifo_rd_en;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;
   logic             m_last;

   modport master (
      input  fifo_empty,
      input  fifo_dout,
      input  m_ready,
      output fifo_rd_en,
      output m_valid,
      output m_data,
      output m_last
   );

   modport slave (
      output fifo_empty,
      output fifo_dout,
      output m_ready,
      input  fifo_rd_en,
      input  m_valid,
      input  m_data,
      input  m_last
   );
endinterface

// File: rtl/fifo_stream_reader.sv
// FIFO read-side consumer: issues rd_en, absorbs the one-cycle read latency into a 2-entry
// skid buffer and presents the words as a valid/ready stream framed into PKT_LEN-beat packets.
module fifo_stream_reader #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned PKT_LEN = 4
) (
   input logic                 rclk,
   input logic                 rst_n,
   fifo_stream_reader_if.master bus
);
   localparam int unsigned    BeatW   = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [BeatW-1:0] BeatMax = BeatW'(PKT_LEN - 1);

   logic [1:0]       occ_q, occ_d;
   logic             pend_q, pend_d;
   logic             run_q, run_d;
   logic [BeatW-1:0] beat_q, beat_d;
   logic [WIDTH-1:0] slot0_q, slot0_d;
   logic [WIDTH-1:0] slot1_q, slot1_d;
   logic             pop;
   logic             rd_en;
   logic             wr_slot1;

   always_comb begin
      pop    = (occ_q != 2'd0) & bus.m_ready;
      occ_d  = occ_q + {1'b0, pend_q} - {1'b0, pop};
      // Words held plus in flight stay within the two skid slots.
      rd_en  = run_q & ~bus.fifo_empty & (occ_d < 2'd2);
      pend_d = rd_en;
      run_d  = 1'b1;

      // Shift only from a full buffer so m_data holds its last value once drained.
      slot0_d  = (pop && (occ_q == 2'd2)) ? slot1_q : slot0_q;
      slot1_d  = slot1_q;
      wr_slot1 = (occ_q == 2'd1) & ~pop;
      if (pend_q) begin
         if (wr_slot1) begin
            slot1_d = bus.fifo_dout;
         end else begin
            slot0_d = bus.fifo_dout;
         end
      end

      beat_d = beat_q;
      if (pop) begin
         beat_d = (beat_q == BeatMax) ? '0 : beat_q + 1'b1;
      end
   end

   always_ff @(posedge rclk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q   <= 2'd0;
         pend_q  <= 1'b0;
         run_q   <= 1'b0;
         beat_q  <= '0;
         slot0_q <= '0;
         slot1_q <= '0;
      end else begin
         occ_q   <= occ_d;
         pend_q  <= pend_d;
         run_q   <= run_d;
         beat_q  <= beat_d;
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
      end
   end

   always_comb begin
      bus.fifo_rd_en = rd_en;
      bus.m_valid    = (occ_q != 2'd0);
      bus.m_data     = slot0_q;
      bus.m_last     = (occ_q != 2'd0) & (beat_q == BeatMax);
   end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based FIFO with one-cycle read latency feeds the DUT,
// and delivered beats are compared with the write log and the beat-index framing rule.
module tb_fifo_stream_reader;
   localparam int unsigned WIDTH   = 8;
   localparam int unsigned PKT_LEN = 4;

   logic rclk  = 1'b0;
   logic rst_n = 1'b0;
   always #5 rclk = ~rclk;

   fifo_stream_reader_if #(.WIDTH(WIDTH)) bus ();

   fifo_stream_reader #(.WIDTH(WIDTH), .PKT_LEN(PKT_LEN)) dut (
      .rclk  (rclk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // FIFO model: words written by the bench, read with one cycle of latency.
   logic [7:0] mem [256];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   logic [7:0] dout_q = 8'h00;
   logic       m_ready_drv = 1'b0;

   assign bus.fifo_empty = (rd_ptr == wr_ptr);
   assign bus.fifo_dout  = dout_q;
   assign bus.m_ready    = m_ready_drv;

   always @(posedge rclk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= wr_ptr;
      end else if (bus.fifo_rd_en && (rd_ptr != wr_ptr)) begin
         dout_q <= mem[rd_ptr % 256];
         rd_ptr <= rd_ptr + 1;
      end
   end

   // Monitor: records pops and read strobes, counts protocol violations.
   int         cyc = 0;
   logic [7:0] got_data [$];
   logic       got_last [$];
   int         got_cyc [$];
   int         rd_cyc [$];
   logic [7:0] exp_log [$];
   int         viol_empty_rd = 0;
   int         viol_stable = 0;
   int         viol_last = 0;
   int         outst = 0;
   int         max_outst = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic       prev_last = 1'b0;

   always @(negedge rclk) begin
      cyc = cyc + 1;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (bus.fifo_rd_en && bus.fifo_empty) viol_empty_rd = viol_empty_rd + 1;
         if (bus.m_last && !bus.m_valid) viol_last = viol_last + 1;
         if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data || bus.m_last !== prev_last))
            viol_stable = viol_stable + 1;
         if (bus.fifo_rd_en) begin
            rd_cyc.push_back(cyc);
            outst = outst + 1;
         end
         if (bus.m_valid && bus.m_ready) begin
            got_data.push_back(bus.m_data);
            got_last.push_back(bus.m_last);
            got_cyc.push_back(cyc);
            outst = outst - 1;
         end
         if (outst > max_outst) max_outst = outst;
         prev_stall = bus.m_valid && !bus.m_ready;
         prev_data  = bus.m_data;
         prev_last  = bus.m_last;
      end
   end

   int checks = 0;
   int failures = 0;

   // Beat i of a stream (counted from reset) closes a packet every PKT_LEN beats.
   function automatic logic last_exp(int i);
      return (i % int'(PKT_LEN)) == int'(PKT_LEN) - 1;
   endfunction

   task automatic push(input logic [7:0] d);
      mem[wr_ptr % 256] = d;
      wr_ptr = wr_ptr + 1;
      exp_log.push_back(d);
   endtask

   task automatic clear_model();
      got_data.delete();
      got_last.delete();
      got_cyc.delete();
      rd_cyc.delete();
      exp_log.delete();
      outst = 0;
      max_outst = 0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge rclk);
      #1;
   endtask

   task automatic do_reset();
      cycles(1);
      rst_n = 1'b0;
      m_ready_drv = 1'b0;
      clear_model();
      cycles(2);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      cycles(2);
      push(8'h5A);
      @(negedge rclk);
      checks++; if (bus.fifo_rd_en !== 1'b0) begin failures++;
         $display("FAIL reset_rd_en: got %b want 0", bus.fifo_rd_en); end
      checks++; if (bus.m_valid !== 1'b0) begin failures++;
         $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
      checks++; if (bus.m_data !== 8'h00) begin failures++;
         $display("FAIL reset_m_data: got %02h want 00", bus.m_data); end
      checks++; if (bus.m_last !== 1'b0) begin failures++;
         $display("FAIL reset_m_last: got %b want 0", bus.m_last); end
      #1;
      rst_n = 1'b1;
      #1;
      checks++; if (bus.fifo_rd_en !== 1'b0) begin failures++;
         $display("FAIL release_rd_en: got %b want 0", bus.fifo_rd_en); end
      @(negedge rclk);
      checks++; if (bus.fifo_rd_en !== 1'b1) begin failures++;
         $display("FAIL first_rd_en: got %b want 1", bus.fifo_rd_en); end
      cycles(1);
      m_ready_drv = 1'b1;
      cycles(5);
      checks++; if (got_data.size() != exp_log.size()) begin failures++;
         $display("FAIL reset_word_count: got %0d want %0d", got_data.size(), exp_log.size()); end
      for (int i = 0; i < got_data.size() && i < exp_log.size(); i++) begin
         checks++;
         if (got_data[i] !== exp_log[i] || got_last[i] !== last_exp(i)) begin failures++;
            $display("FAIL reset_beat%0d: got %02h/%b want %02h/%b", i, got_data[i], got_last[i],
                     exp_log[i], last_exp(i)); end
      end
   endtask

   task automatic test_stream();
      do_reset();
      m_ready_drv = 1'b1;
      push(8'h11); push(8'h22); push(8'h33);
      cycles(8);
      checks++; if (rd_cyc.size() != 3) begin failures++;
         $display("FAIL stream_rd_count: got %0d want 3", rd_cyc.size()); end
      if (rd_cyc.size() == 3) begin
         checks++; if (rd_cyc[2] - rd_cyc[0] != 2) begin failures++;
            $display("FAIL stream_rd_consecutive: got span %0d want 2", rd_cyc[2] - rd_cyc[0]); end
      end
      checks++; if (got_data.size() != 3) begin failures++;
         $display("FAIL stream_count: got %0d want 3", got_data.size()); end
      if (got_data.size() == 3 && rd_cyc.size() > 0) begin
         checks++; if (got_cyc[0] - rd_cyc[0] != 2) begin failures++;
            $display("FAIL stream_latency: got %0d want 2", got_cyc[0] - rd_cyc[0]); end
         checks++; if (got_cyc[2] - got_cyc[0] != 2) begin failures++;
            $display("FAIL stream_gapless: got span %0d want 2", got_cyc[2] - got_cyc[0]); end
      end
      for (int i = 0; i < got_data.size() && i < exp_log.size(); i++) begin
         checks++;
         if (got_data[i] !== exp_log[i] || got_last[i] !== last_exp(i)) begin failures++;
            $display("FAIL stream_beat%0d: got %02h/%b want %02h/%b", i, got_data[i], got_last[i],
                     exp_log[i], last_exp(i)); end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int i = 1; i <= 5; i++) push(8'(i));
      cycles(10);
      checks++; if (rd_cyc.size() != 2) begin failures++;
         $display("FAIL bp_rd_count: got %0d want 2", rd_cyc.size()); end
      checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h01) begin failures++;
         $display("FAIL bp_hold: got valid=%b data=%02h want 1/01", bus.m_valid, bus.m_data); end
      checks++; if (viol_stable != 0) begin failures++;
         $display("FAIL bp_stable: got %0d violations want 0", viol_stable); end
      m_ready_drv = 1'b1;
      cycles(10);
      checks++; if (got_data.size() != 5 || rd_cyc.size() != 5) begin failures++;
         $display("FAIL bp_count: got pops=%0d reads=%0d want 5/5", got_data.size(), rd_cyc.size());
      end
      if (got_data.size() == 5) begin
         checks++; if (got_cyc[4] - got_cyc[0] != 4) begin failures++;
            $display("FAIL bp_gapless: got span %0d want 4", got_cyc[4] - got_cyc[0]); end
      end
      for (int i = 0; i < got_data.size() && i < exp_log.size(); i++) begin
         checks++;
         if (got_data[i] !== exp_log[i] || got_last[i] !== last_exp(i)) begin failures++;
            $display("FAIL bp_beat%0d: got %02h/%b want %02h/%b", i, got_data[i], got_last[i],
                     exp_log[i], last_exp(i)); end
      end
   endtask

   task automatic test_random();
      int n;
      int lasts;
      do_reset();
      for (int i = 0; i < 10; i++) push(8'($urandom));
      n = 0;
      while (got_data.size() < 10 && n < 300) begin
         m_ready_drv = 1'($urandom_range(0, 1));
         cycles(1);
         n++;
      end
      m_ready_drv = 1'b0;
      checks++; if (got_data.size() != 10) begin failures++;
         $display("FAIL rand_count: got %0d want 10", got_data.size()); end
      lasts = 0;
      for (int i = 0; i < got_data.size() && i < exp_log.size(); i++) begin
         if (got_last[i]) lasts++;
         checks++;
         if (got_data[i] !== exp_log[i] || got_last[i] !== last_exp(i)) begin failures++;
            $display("FAIL rand_beat%0d: got %02h/%b want %02h/%b", i, got_data[i], got_last[i],
                     exp_log[i], last_exp(i)); end
      end
      checks++; if (lasts != 2) begin failures++;
         $display("FAIL rand_last_count: got %0d want 2", lasts); end
      checks++; if (viol_stable != 0 || viol_last != 0 || max_outst > 2) begin failures++;
         $display("FAIL rand_protocol: got stable=%0d last=%0d outst=%0d want 0/0/<=2",
                  viol_stable, viol_last, max_outst); end
   endtask

   task automatic test_drain();
      do_reset();
      m_ready_drv = 1'b1;
      for (int i = 0; i < 6; i++) push(8'($urandom));
      cycles(12);
      checks++; if (bus.m_valid !== 1'b0 || bus.fifo_rd_en !== 1'b0) begin failures++;
         $display("FAIL drain_idle: got valid=%b rd_en=%b want 0/0", bus.m_valid, bus.fifo_rd_en);
      end
      checks++; if (got_data.size() != 6) begin failures++;
         $display("FAIL drain_count: got %0d want 6", got_data.size()); end
      push(8'h07); push(8'h08);
      cycles(8);
      checks++; if (got_data.size() != 8) begin failures++;
         $display("FAIL refill_count: got %0d want 8", got_data.size()); end
      for (int i = 0; i < got_data.size() && i < exp_log.size(); i++) begin
         checks++;
         if (got_data[i] !== exp_log[i] || got_last[i] !== last_exp(i)) begin failures++;
            $display("FAIL drain_beat%0d: got %02h/%b want %02h/%b", i, got_data[i], got_last[i],
                     exp_log[i], last_exp(i)); end
      end
      checks++; if (viol_empty_rd != 0) begin failures++;
         $display("FAIL rd_while_empty: got %0d occurrences want 0", viol_empty_rd); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      m_ready_drv = 1'b1;
      for (int i = 0; i < 8; i++) push(8'($urandom_range(1, 255)));
      cycles(4);
      m_ready_drv = 1'b0;
      cycles(3);
      checks++; if (bus.m_valid !== 1'b1) begin failures++;
         $display("FAIL mid_precond_valid: got %b want 1", bus.m_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.m_valid !== 1'b0 || bus.m_data !== 8'h00 || bus.m_last !== 1'b0 ||
          bus.fifo_rd_en !== 1'b0) begin failures++;
         $display("FAIL mid_reset_outputs: got v=%b d=%02h l=%b rd=%b want 0/00/0/0",
                  bus.m_valid, bus.m_data, bus.m_last, bus.fifo_rd_en); end
      clear_model();
      cycles(2);
      rst_n = 1'b1;
      push(8'hAA);
      for (int i = 0; i < 4; i++) push(8'($urandom));
      m_ready_drv = 1'b1;
      cycles(12);
      checks++; if (got_data.size() != 5) begin failures++;
         $display("FAIL mid_count: got %0d want 5", got_data.size()); end
      for (int i = 0; i < got_data.size() && i < exp_log.size(); i++) begin
         checks++;
         if (got_data[i] !== exp_log[i] || got_last[i] !== last_exp(i)) begin failures++;
            $display("FAIL mid_beat%0d: got %02h/%b want %02h/%b", i, got_data[i], got_last[i],
                     exp_log[i], last_exp(i)); end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_random();
      test_drain();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
